pc_fetch_ctrl: RTL and testbench

- Instruction-fetch initiator for the multi-cycle NPC core.
- Owns the PC register and issues one fetch request at a time to instruction memory over a valid/ready handshake.
- Hands the fetched instruction to decode, then waits for execute to retire it with the branch comparator's `PCSel` decision and target.
- Non-speculative: exactly one instruction is in flight between fetch and retire.

---
 rtl/pc_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction-fetch initiator for the multi-cycle NPC core.
// Owns the PC, issues one fetch at a time over a valid/ready handshake,
// hands the instruction to decode and waits for execute to retire it.
// Optional feature macro: PC_MISALIGN_CHECK_EN. When it is defined, a taken
// target with pc_target[1:0] != 0 halts the block and sets misalign_err.
module pc_fetch_ctrl #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_valid,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_resp_valid,
  input  logic [31:0]           ifu_resp_inst,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready,
  input  logic                  exec_done,
  input  logic                  pc_sel,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  retire;
  logic                  bad_target;
  logic [ADDR_WIDTH-1:0] pc_next;

  // Retire event and next-PC selection; ISSUE retires only with inst_ready
  always_comb begin
    retire  = exec_done & ((state == S_EXEC) | ((state == S_ISSUE) & inst_ready));
    pc_next = pc_sel ? pc_target : pc + ADDR_WIDTH'(4);
`ifdef PC_MISALIGN_CHECK_EN
    bad_target = pc_sel & (pc_target[1:0] != 2'b00);
`else
    bad_target = 1'b0;
`endif
  end

  // Fetch FSM: PC, latched instruction and state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      unique case (state)
        S_IDLE:  state <= S_REQ;
        S_REQ:   if (ifu_req_ready) state <= S_WAIT;
        S_WAIT: begin
          if (ifu_resp_valid) begin
            inst    <= ifu_resp_inst;
            inst_pc <= pc;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE, S_EXEC: begin
          if (retire) begin
            if (bad_target) begin
              state <= S_HALT;
            end else begin
              pc    <= pc_next;
              state <= S_REQ;
            end
          end else if (state == S_ISSUE && inst_ready) begin
            state <= S_EXEC;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_q;

  // Sticky error flag, set on the same edge that enters HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    misalign_q <= 1'b0;
    else if (retire && bad_target) misalign_q <= 1'b1;
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  // Outputs decoded from state and PC registers only
  assign ifu_req_valid = (state == S_REQ);
  assign ifu_req_addr  = pc;
  assign inst_valid    = (state == S_ISSUE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl. Inputs change 1 ns after the rising
// edge; outputs are checked at the same point, after the edge settled.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        exec_done;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        misalign_err;

  int n_cmp;
  int n_err;
  int acc_cnt;

  pc_fetch_ctrl #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_inst  (ifu_resp_inst),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .exec_done      (exec_done),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request acceptances seen at rising edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (ifu_req_valid && ifu_req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full fetch from REQ: accept, respond next cycle, retire with inst_ready
  task automatic run_txn(input logic [31:0] word, input logic sel, input logic [31:0] tgt);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = word;
    step();
    ifu_resp_valid = 1'b0;
    inst_ready     = 1'b1;
    exec_done      = 1'b1;
    pc_sel         = sel;
    pc_target      = tgt;
    step();
    inst_ready = 1'b0;
    exec_done  = 1'b0;
    pc_sel     = 1'b0;
    pc_target  = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_inst = '0;
    inst_ready = 1'b0;
    exec_done = 1'b0;
    pc_sel = 1'b0;
    pc_target = '0;

    step();
    step();
    check("rst_req_valid", 32'(ifu_req_valid), 32'd0);
    check("rst_req_addr", ifu_req_addr, 32'h8000_0000);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // Release reset: first request after the first edge
    rst_n = 1'b1;
    step();
    check("first_req_valid", 32'(ifu_req_valid), 32'd1);
    check("first_req_addr", ifu_req_addr, 32'h8000_0000);

    ifu_req_ready = 1'b1;
    step();
    check("wait_req_valid", 32'(ifu_req_valid), 32'd0);
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = 32'h0000_0013;
    step();
    ifu_resp_valid = 1'b0;
    check("issue_inst_valid", 32'(inst_valid), 32'd1);
    check("issue_inst", inst, 32'h0000_0013);
    check("issue_inst_pc", inst_pc, 32'h8000_0000);

    // Decode stalls one cycle, then accepts
    step();
    check("issue_hold", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("exec_inst_valid", 32'(inst_valid), 32'd0);
    check("exec_req_valid", 32'(ifu_req_valid), 32'd0);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    check("seq_req_valid", 32'(ifu_req_valid), 32'd1);
    check("seq_req_addr", ifu_req_addr, 32'h8000_0004);

    // Memory stalls 5 cycles; stray exec_done/resp_valid are ignored in REQ
    for (int i = 0; i < 5; i++) begin
      exec_done      = (i == 1);
      pc_sel         = (i == 1);
      pc_target      = 32'h1234_5678;
      ifu_resp_valid = (i == 2);
      ifu_resp_inst  = 32'hDEAD_BEEF;
      step();
      check("stall_req_valid", 32'(ifu_req_valid), 32'd1);
      check("stall_req_addr", ifu_req_addr, 32'h8000_0004);
    end
    exec_done = 1'b0;
    pc_sel = 1'b0;
    pc_target = '0;
    ifu_resp_valid = 1'b0;
    check("stall_inst_kept", inst, 32'h0000_0013);
    check("stall_acc_cnt", 32'(acc_cnt), 32'd1);

    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    check("accept_once", 32'(acc_cnt), 32'd2);
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = 32'h0010_0093;
    step();
    ifu_resp_valid = 1'b0;
    check("second_inst", inst, 32'h0010_0093);
    check("second_inst_pc", inst_pc, 32'h8000_0004);

    // inst_ready and taken exec_done together: straight back to REQ
    inst_ready = 1'b1;
    exec_done  = 1'b1;
    pc_sel     = 1'b1;
    pc_target  = 32'h8000_0100;
    step();
    inst_ready = 1'b0;
    exec_done  = 1'b0;
    pc_sel     = 1'b0;
    pc_target  = '0;
    check("taken_req_valid", 32'(ifu_req_valid), 32'd1);
    check("taken_req_addr", ifu_req_addr, 32'h8000_0100);

    // Wrap-around at the top of the address space
    run_txn(32'h0000_0013, 1'b1, 32'hFFFF_FFFC);
    check("top_req_addr", ifu_req_addr, 32'hFFFF_FFFC);
    run_txn(32'h0000_0013, 1'b0, 32'h0);
    check("wrap_req_valid", 32'(ifu_req_valid), 32'd1);
    check("wrap_req_addr", ifu_req_addr, 32'h0000_0000);

    // Reset pulse while waiting for a response
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(ifu_req_valid), 32'd0);
    check("midrst_req_addr", ifu_req_addr, 32'h8000_0000);
    check("midrst_inst_valid", 32'(inst_valid), 32'd0);
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = 32'hCAFE_F00D;
    step();
    rst_n = 1'b1;
    step();
    ifu_resp_valid = 1'b0;
    check("refetch_req_valid", 32'(ifu_req_valid), 32'd1);
    check("refetch_req_addr", ifu_req_addr, 32'h8000_0000);
    check("late_resp_ignored", inst, 32'd0);

    // Misaligned taken target
    run_txn(32'h0000_0013, 1'b1, 32'h8000_0102);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_req_valid", 32'(ifu_req_valid), 32'd0);
    ifu_req_ready = 1'b1;
    step();
    step();
    step();
    ifu_req_ready = 1'b0;
    check("halt_req_valid", 32'(ifu_req_valid), 32'd0);
    check("halt_inst_valid", 32'(inst_valid), 32'd0);
    check("halt_err_sticky", 32'(misalign_err), 32'd1);
`else
    check("mis_err", 32'(misalign_err), 32'd0);
    check("mis_req_valid", 32'(ifu_req_valid), 32'd1);
    check("mis_req_addr", ifu_req_addr, 32'h8000_0102);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
